// File: rtl/dcache_req_sched_if.sv
// Request/response bundle between the memory stage, the CACOP unit, the
// data cache and the dcache request scheduler.
// slave  : the scheduler's view.
// master : the surrounding pipeline/cache view (drives what the scheduler reads).
interface dcache_req_sched_if #(
    parameter int EXC_W = 7
);
    logic             flush;

    logic             lsu_valid;
    logic             lsu_ready;
    logic [31:0]      lsu_addr;
    logic [3:0]       lsu_type;
    logic             lsu_we;
    logic [31:0]      lsu_wdata;

    logic             cacop_valid;
    logic             cacop_ready;
    logic [31:0]      cacop_addr;
    logic [4:0]       cacop_code;

    logic             cache_valid;
    logic             cache_ready;
    logic [31:0]      cache_addr;
    logic [3:0]       cache_type;
    logic             cache_we;
    logic [31:0]      cache_wdata;
    logic             cache_cacop_en;
    logic [4:0]       cache_cacop_code;
    logic             cache_resp_valid;
    logic [31:0]      cache_rdata;

    logic             resp_valid;
    logic             resp_src;
    logic [31:0]      resp_rdata;
    logic [EXC_W-1:0] resp_exception;

    modport slave (
        input  flush,
        input  lsu_valid, lsu_addr, lsu_type, lsu_we, lsu_wdata,
        output lsu_ready,
        input  cacop_valid, cacop_addr, cacop_code,
        output cacop_ready,
        output cache_valid, cache_addr, cache_type, cache_we, cache_wdata,
        output cache_cacop_en, cache_cacop_code,
        input  cache_ready, cache_resp_valid, cache_rdata,
        output resp_valid, resp_src, resp_rdata, resp_exception
    );

    modport master (
        output flush,
        output lsu_valid, lsu_addr, lsu_type, lsu_we, lsu_wdata,
        input  lsu_ready,
        output cacop_valid, cacop_addr, cacop_code,
        input  cacop_ready,
        input  cache_valid, cache_addr, cache_type, cache_we, cache_wdata,
        input  cache_cacop_en, cache_cacop_code,
        output cache_ready, cache_resp_valid, cache_rdata,
        input  resp_valid, resp_src, resp_rdata, resp_exception
    );
endinterface

// File: rtl/dcache_req_sched.sv
// Data-cache request scheduler: round-robin arbitration between the LSU and
// the CACOP unit, one buffered request outstanding at a time. Misaligned LSU
// accesses are answered locally with ALE; everything else goes to the dcache.
module dcache_req_sched #(
    parameter int               EXC_W   = 7,
    // ALE exception code; default is the LoongArch ALE ecode (0x9)
    parameter logic [EXC_W-1:0] EXP_ALE = 'h9
) (
    input logic               clk,
    input logic               rstn,
    dcache_req_sched_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT} state_t;

    state_t           state_reg;
    logic             last_grant_reg;   // 0 = LSU, 1 = CACOP
    logic             drop_reg;         // response of a flushed in-flight request is swallowed

    logic [31:0]      buf_addr_reg;
    logic [3:0]       buf_type_reg;
    logic             buf_we_reg;
    logic [31:0]      buf_wdata_reg;
    logic             buf_cacop_reg;
    logic [4:0]       buf_code_reg;

    logic             cache_valid_reg;
    logic             resp_valid_reg;
    logic             resp_src_reg;
    logic [31:0]      resp_rdata_reg;
    logic [EXC_W-1:0] resp_exc_reg;

    logic             can_grant;
    logic             grant_lsu;
    logic             grant_cacop;
    logic             misaligned;
    logic             cache_done;
    logic             drop_now;

    // Round-robin grant; the IDLE cycle that shows a response is a turnaround
    // cycle, so the next grant lands in the cycle after resp_valid.
    always_comb begin
        can_grant   = rstn && (state_reg == S_IDLE) && !bus.flush && !resp_valid_reg;
        grant_lsu   = can_grant && bus.lsu_valid && (!bus.cacop_valid || last_grant_reg);
        grant_cacop = can_grant && bus.cacop_valid && (!bus.lsu_valid || !last_grant_reg);
    end

    // Alignment check on the buffered request; CACOPs never fault.
    always_comb begin
        misaligned = 1'b0;
        if (!buf_cacop_reg) begin
            if (buf_type_reg == 4'b1111)
                misaligned = (buf_addr_reg[1:0] != 2'b00);
            else if (buf_type_reg == 4'b0011)
                misaligned = buf_addr_reg[0];
        end
    end

    // Cache transaction completes when the response is seen after (or with) the handshake.
    always_comb begin
        cache_done = ((state_reg == S_ISSUE) && bus.cache_ready && bus.cache_resp_valid)
                  || ((state_reg == S_WAIT) && bus.cache_resp_valid);
        drop_now   = drop_reg || bus.flush;
    end

    assign bus.lsu_ready        = grant_lsu;
    assign bus.cacop_ready      = grant_cacop;
    assign bus.cache_valid      = cache_valid_reg;
    assign bus.cache_addr       = buf_addr_reg;
    assign bus.cache_type       = buf_type_reg;
    assign bus.cache_we         = buf_we_reg;
    assign bus.cache_wdata      = buf_wdata_reg;
    assign bus.cache_cacop_en   = buf_cacop_reg;
    assign bus.cache_cacop_code = buf_code_reg;
    assign bus.resp_valid       = resp_valid_reg;
    assign bus.resp_src         = resp_src_reg;
    assign bus.resp_rdata       = resp_rdata_reg;
    assign bus.resp_exception   = resp_exc_reg;

    // Scheduler FSM with registered buffer, cache request and response outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg       <= S_IDLE;
            last_grant_reg  <= 1'b1;
            drop_reg        <= 1'b0;
            buf_addr_reg    <= '0;
            buf_type_reg    <= '0;
            buf_we_reg      <= 1'b0;
            buf_wdata_reg   <= '0;
            buf_cacop_reg   <= 1'b0;
            buf_code_reg    <= '0;
            cache_valid_reg <= 1'b0;
            resp_valid_reg  <= 1'b0;
            resp_src_reg    <= 1'b0;
            resp_rdata_reg  <= '0;
            resp_exc_reg    <= '0;
        end else begin
            resp_valid_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    drop_reg <= 1'b0;
                    if (grant_lsu) begin
                        buf_addr_reg   <= bus.lsu_addr;
                        buf_type_reg   <= bus.lsu_type;
                        buf_we_reg     <= bus.lsu_we;
                        buf_wdata_reg  <= bus.lsu_wdata;
                        buf_cacop_reg  <= 1'b0;
                        buf_code_reg   <= '0;
                        last_grant_reg <= 1'b0;
                        state_reg      <= S_CHECK;
                    end else if (grant_cacop) begin
                        buf_addr_reg   <= bus.cacop_addr;
                        buf_type_reg   <= 4'b1111;
                        buf_we_reg     <= 1'b0;
                        buf_wdata_reg  <= '0;
                        buf_cacop_reg  <= 1'b1;
                        buf_code_reg   <= bus.cacop_code;
                        last_grant_reg <= 1'b1;
                        state_reg      <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (bus.flush) begin
                        state_reg <= S_IDLE;
                    end else if (misaligned) begin
                        resp_valid_reg <= 1'b1;
                        resp_src_reg   <= buf_cacop_reg;
                        resp_rdata_reg <= '0;
                        resp_exc_reg   <= EXP_ALE;
                        state_reg      <= S_IDLE;
                    end else begin
                        cache_valid_reg <= 1'b1;
                        state_reg       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.flush)
                        drop_reg <= 1'b1;
                    if (bus.cache_ready) begin
                        cache_valid_reg <= 1'b0;
                        state_reg       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.flush)
                        drop_reg <= 1'b1;
                end
            endcase
            if (cache_done) begin
                state_reg <= S_IDLE;
                if (!drop_now) begin
                    resp_valid_reg <= 1'b1;
                    resp_src_reg   <= buf_cacop_reg;
                    resp_rdata_reg <= (buf_we_reg || buf_cacop_reg) ? 32'h0 : bus.cache_rdata;
                    resp_exc_reg   <= '0;
                end
            end
        end
    end
endmodule
